seven_seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment display driver: scans NUM_DIGITS hex digits onto shared

---
 rtl/seven_seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan driver: hex decode, leading-zero blanking, PWM brightness
// and a pending/active double buffer that only swaps at the frame wrap.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 10000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_XOR  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_XOR   = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("seven_seg_scan_ctrl: NUM_DIGITS must be in 1..8");
  end
  if ((DIV < 2) || (DIV < (2 ** BRIGHT_W))) begin : g_bad_div
    $error("seven_seg_scan_ctrl: DIV must be >= 2 and >= 2**BRIGHT_W");
  end

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [DIV_W-1:0]        div_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BRIGHT_W-1:0]     pwm_cnt_r;
  logic [4*NUM_DIGITS-1:0] pend_data_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic                    pend_valid_r;
  logic [4*NUM_DIGITS-1:0] act_data_r;
  logic [NUM_DIGITS-1:0]   act_dp_r;
  logic [7:0]              seg_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_done_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic                    lit_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic                    zero_run_s;
  logic                    sel_s;
  logic [NUM_DIGITS-1:0]   an_hi_s;
  logic [7:0]              seg_next_s;
  logic [NUM_DIGITS-1:0]   an_next_s;

  assign tick_s = (div_cnt_r == DIV_LAST);
  assign wrap_s = tick_s && (idx_r == {IDX_W{1'b0}});
  assign lit_s  = (&brightness) || (pwm_cnt_r < brightness);

  // Select the scanned digit; zero_run_s tracks "all nibbles from the left down to here are 0".
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    zero_run_s  = 1'b1;
    sel_s       = 1'b0;
    an_hi_s     = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s  = zero_run_s && (act_data_r[4*i +: 4] == 4'h0);
      sel_s       = (idx_r == IDX_W'(i));
      cur_nib_s   = cur_nib_s | ({4{sel_s}} & act_data_r[4*i +: 4]);
      cur_dp_s    = cur_dp_s | (sel_s & act_dp_r[i]);
      cur_blank_s = cur_blank_s | (sel_s & blank_lz & zero_run_s & (i != 0));
      an_hi_s[i]  = sel_s & lit_s;
    end
    seg_next_s = {cur_dp_s, (cur_blank_s ? 7'h00 : hex_to_seg(cur_nib_s))} ^ SEG_XOR;
    an_next_s  = an_hi_s ^ AN_XOR;
  end

  // Slot divider, scan index (leftmost first) and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      idx_r     <= IDX_LAST;
      pwm_cnt_r <= {BRIGHT_W{1'b0}};
    end else begin
      div_cnt_r <= tick_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
      pwm_cnt_r <= pwm_cnt_r + BRIGHT_W'(1);
      if (tick_s) begin
        idx_r <= (idx_r == {IDX_W{1'b0}}) ? IDX_LAST : (idx_r - IDX_W'(1));
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Double buffer: the swap reads pending before any same-cycle load, so that load survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_valid_r <= 1'b0;
      act_data_r   <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
    end else begin
      if (load) begin
        pend_data_r  <= data_in;
        pend_dp_r    <= dp_in;
        pend_valid_r <= 1'b1;
      end else if (wrap_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
      if (wrap_s && pend_valid_r) begin
        act_data_r <= pend_data_r;
        act_dp_r   <= pend_dp_r;
      end else begin
        act_data_r <= act_data_r;
        act_dp_r   <= act_dp_r;
      end
    end
  end

  // Output registers; frame_done is anticipated one cycle so it coincides with the wrap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r        <= SEG_XOR;
      an_r         <= AN_XOR;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_next_s;
      an_r         <= an_next_s;
      frame_done_r <= (div_cnt_r == DIV_PRE) && (idx_r == {IDX_W{1'b0}});
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (4 digits, DIV=16, active-low outputs).
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] an_tab   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [7:0] seg_12af [4] = '{8'hF9, 8'hA4, 8'h88, 8'h8E};
  logic [7:0] seg_0012 [4] = '{8'hFF, 8'h7F, 8'hF9, 8'hA4};
  logic [7:0] seg_0000 [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hC0};
  logic [7:0] seg_3456 [4] = '{8'hB0, 8'h99, 8'h92, 8'h82};
  logic [7:0] seg_789a [4] = '{8'hF8, 8'h80, 8'h90, 8'h88};

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .DIV(16), .BRIGHT_W(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Leaves the bench on the negedge where frame_done is high (the wrap cycle).
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_frame: frame_done=%b after 200 cycles, required 1", frame_done);
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = 16'h0000; dp_in = 4'h0; load = 1'b0;
    blank_lz = 1'b0; brightness = 4'hF;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (seg !== 8'hFF) begin miscompares++; $display("FAIL reset_seg: got %h want FF", seg); end
    if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an: got %b want 1111", an); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (an !== 4'b0111) begin miscompares++; $display("FAIL release_an: got %b want 0111", an); end
    if (seg !== 8'hC0) begin miscompares++; $display("FAIL release_seg: got %h want C0", seg); end
  endtask

  task automatic test_scan();
    load_word(16'h12AF, 4'h0);
    wait_frame();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      if (j > 0) @(negedge clk);
      vectors += 3;
      if (an !== an_tab[j/16]) begin miscompares++; $display("FAIL scan_an c%0d: got %b want %b", j, an, an_tab[j/16]); end
      if (seg !== seg_12af[j/16]) begin miscompares++; $display("FAIL scan_seg c%0d: got %h want %h", j, seg, seg_12af[j/16]); end
      if (frame_done !== (j == 62)) begin miscompares++; $display("FAIL scan_fd c%0d: got %b want %b", j, frame_done, (j == 62)); end
    end
  endtask

  task automatic test_double_buffer();
    logic [7:0] want;
    wait_frame();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 128; j++) begin
      if (j > 0) @(negedge clk);
      want = (j < 64) ? seg_12af[(j%64)/16] : 8'hA4;
      vectors += 2;
      if (an !== an_tab[(j%64)/16]) begin miscompares++; $display("FAIL dbuf_an c%0d: got %b want %b", j, an, an_tab[(j%64)/16]); end
      if (seg !== want) begin miscompares++; $display("FAIL dbuf_seg c%0d: got %h want %h", j, seg, want); end
      if (j == 18) begin data_in = 16'h1111; load = 1'b1; end
      else if (j == 38) begin data_in = 16'h2222; load = 1'b1; end
      else load = 1'b0;
    end
  endtask

  task automatic test_blanking();
    logic [7:0] want;
    blank_lz = 1'b1;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) load_word(16'h0012, 4'b0100);
      else load_word(16'h0000, 4'b0000);
      wait_frame();
      repeat (2) @(negedge clk);
      for (int j = 0; j < 64; j++) begin
        if (j > 0) @(negedge clk);
        want = (f == 0) ? seg_0012[j/16] : seg_0000[j/16];
        vectors++;
        if (seg !== want) begin miscompares++; $display("FAIL blank%0d_seg c%0d: got %h want %h", f, j, seg, want); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_brightness();
    int cnt;
    brightness = 4'h0;
    wait_frame();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      if (j > 0) @(negedge clk);
      vectors++;
      if (an !== 4'hF) begin miscompares++; $display("FAIL bright0_an c%0d: got %b want 1111", j, an); end
    end
    brightness = 4'h8;
    wait_frame();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
        if (s > 0 || c > 0) @(negedge clk);
        if (an !== 4'hF) cnt++;
        vectors++;
        if (an !== 4'hF && an !== an_tab[s]) begin miscompares++; $display("FAIL bright8_an s%0d c%0d: got %b want %b or 1111", s, c, an, an_tab[s]); end
      end
      vectors++;
      if (cnt != 8) begin miscompares++; $display("FAIL bright8_duty s%0d: got %0d lit cycles want 8", s, cnt); end
    end
    brightness = 4'hF;
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    wait_frame();
    repeat (10) @(negedge clk);
    load_word(16'h3456, 4'h0);
    wait_frame();
    data_in = 16'h789A; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 128; j++) begin
      if (j > 0) @(negedge clk);
      if (j % 16 == 8) begin
        want = (j < 64) ? seg_3456[(j%64)/16] : seg_789a[(j%64)/16];
        vectors++;
        if (seg !== want) begin miscompares++; $display("FAIL wrapload_seg c%0d: got %h want %h", j, seg, want); end
      end
    end
    repeat (5) @(negedge clk);
    load_word(16'hFFFF, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (seg !== 8'hFF) begin miscompares++; $display("FAIL midrst_seg: got %h want FF", seg); end
    if (an !== 4'hF) begin miscompares++; $display("FAIL midrst_an: got %b want 1111", an); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL midrst_fd: got %b want 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (an !== 4'b0111) begin miscompares++; $display("FAIL midrst_release_an: got %b want 0111", an); end
    wait_frame();
    repeat (2) @(negedge clk);
    vectors += 2;
    if (seg !== 8'hC0) begin miscompares++; $display("FAIL midrst_pending_seg: got %h want C0", seg); end
    if (an !== 4'b0111) begin miscompares++; $display("FAIL midrst_pending_an: got %b want 0111", an); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_buffer();
    test_blanking();
    test_brightness();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
